pwm_breath_multi: RTL and testbench
===================================

# pwm_breath_multi

Multi-channel breathing-LED PWM generator. It is the parametrised successor of the single-LED breathing block: channel count, PWM resolution and timebase are parameters; each channel has a run-time mode (off, on, breath, blink); and channels can start phase-staggered. It sits between the board clock and the LED pins and needs no software beyond static mode straps.

## Interface
- `CH_NUM`, 4: number of LED channels (≥1).
- `PRESC_MAX`, 50: sys_clk cycles per PWM tick (≥1); default gives a 1 µs tick at 50 MHz.
- `STEPS`, 1000: ticks per PWM period, which is also the number of duty levels (≥2).
- `PHASE_SPREAD`, 1: 1 staggers the channels' breath phase evenly; 0 keeps all channels in phase.

- `sys_clk`  in  1  system clock.
- `sys_rst`  in  1  asynchronous, active-high reset.
- `enable`  in  1  run/freeze control.
- `mode`  in  2*CH_NUM  per-channel mode. Bits [2i+1:2i] belong to channel i: 00 off, 01 on, 10 breath, 11 blink.
- `led_out`  out  CH_NUM  registered LED drive, active-high.
- `period_pulse`  out  1  one-cycle strobe on the last clock of each PWM period.

## Operation
- **Prescaler.** `cnt_pre` counts 0..PRESC_MAX-1. `tick` = (cnt_pre==PRESC_MAX-1) && enable.
- **PWM counter.** `cnt_pwm` counts 0..STEPS-1 and advances on `tick`. `period_end` = tick && cnt_pwm==STEPS-1. `period_pulse` is the registered `period_end`.
- **Per-channel state.** Each channel holds a level `lvl_i` (0..STEPS-1) and a direction `dir_i` (0 = up, 1 = down). These update only on `period_end`:
  - Up at the top: if lvl==STEPS-1, then lvl←STEPS-2 and dir←1; otherwise lvl+1.
  - Down at the bottom: if lvl==0, then lvl←1 and dir←0; otherwise lvl-1.
  - One breath cycle therefore lasts 2*(STEPS-1) periods.
- **Reset phase.** Let p_i = i*2*(STEPS-1)/CH_NUM (integer division), or 0 when PHASE_SPREAD=0.
  - If p_i ≤ STEPS-1: lvl_i = p_i, dir_i = 0.
  - Otherwise: lvl_i = 2*(STEPS-1)-p_i, dir_i = 1.
- **Mode shadow.** `mode_q_i` loads `mode` on `period_end`, and continuously while enable=0. Mode changes therefore never truncate a period.
- **Output function**, by `mode_q_i`:
  - off: 0.
  - on: 1.
  - breath: cnt_pwm < lvl_i (duty = lvl_i/STEPS; level 0 gives 0 %).
  - blink: dir_i.
- **enable=0.** All counters, levels and directions freeze. led_out and period_pulse are forced to 0. Counting resumes from the frozen state when enable returns to 1.
- **Widths.** Counter widths are $clog2 of their max+1. The p_i computation is done at elaboration in 32-bit integer arithmetic.

## Timing
- **Reset values** (asynchronous): cnt_pre=0, cnt_pwm=0, led_out=0, period_pulse=0, mode_q=off, and lvl/dir at the reset phase above.
- **Output latency.** led_out is registered: it reflects cnt_pwm, lvl and mode_q with one cycle of latency.
- **period_pulse** is asserted in the cycle after the clock on which the last tick of the period occurs.
- **Period length** = PRESC_MAX*STEPS clocks with enable held high; defaults give 50 000 clocks (1 ms) and a breath cycle of about 2 s.
- **Mode effect.** A mode change becomes visible on led_out one cycle after the next period_end.
- **Reset mid-period.** Outputs go to 0 immediately. The first period_pulse after reset release comes PRESC_MAX*STEPS clocks later.

## Structure
- Package `pwm_breath_pkg` holds:
  - the mode localparams MODE_OFF, MODE_ON, MODE_BREATH, MODE_BLINK;
  - the function `phase_init(i, CH_NUM, STEPS)`, which returns {dir, lvl}.
- Sub-module `pwm_breath_ch` contains one channel's lvl/dir/mode_q/output logic. It is instantiated CH_NUM times in a generate loop and takes `period_end`, `cnt_pwm` and `enable` as inputs.
- The top level owns the prescaler, cnt_pwm and period_pulse.

## Test plan
All scenarios use PRESC_MAX=2 and STEPS=4, so a period is 8 clocks and a breath cycle is 6 periods.
1. **Reset.** Assert sys_rst mid-period → led_out=0 and period_pulse=0 without waiting for a clock edge. After release, the first period_pulse arrives 8 clocks later, then every 8 clocks.
2. **Breath.** PHASE_SPREAD=0, all modes 10 → ch0 high-time per period after the first period_end is 2,4,6,4,2,0,2,… clocks, starting at cnt_pwm=0.
3. **Phase stagger.** PHASE_SPREAD=1, CH_NUM=4 → reset levels are 0,1,3,2 with dir 0,0,0,1, checked on the first breath period's duty.
4. **Mode change mid-period.** Switch ch1 from 10 to 01 on clock 3 of a period → old waveform continues to period_end; led_out[1]=1 from one cycle after period_end.
5. **Freeze.** Deassert enable for 5 clocks → led_out=0 for those clocks; the next period_pulse is delayed by exactly 5 clocks; duty sequence continues unchanged.
6. **Blink.** Mode 11 → led_out toggles every 3 periods (24 clocks) in steady state; the first high interval after reset is 4 periods minus the mode-load period.

Source files
------------

// File: rtl/pwm_breath_pkg.sv
// ---------------------------------------------------------------------------
// pwm_breath_pkg
// Shared definitions for the multi-channel breathing-LED PWM generator.
//   MODE_*      : 2-bit per-channel mode encodings (off / on / breath / blink)
//   phase_init  : elaboration-time reset phase of channel i, returns {dir, lvl}
//   cnt_width   : bit width needed to hold 0..max_val (never less than 1)
// ---------------------------------------------------------------------------
package pwm_breath_pkg;

    localparam logic [1:0] MODE_OFF    = 2'b00;
    localparam logic [1:0] MODE_ON     = 2'b01;
    localparam logic [1:0] MODE_BREATH = 2'b10;
    localparam logic [1:0] MODE_BLINK  = 2'b11;

    // Reset phase of channel i spread evenly over one breath cycle of
    // 2*(steps-1) periods. The first half of the cycle is the rising ramp
    // (dir=0), the second half is mirrored onto the falling ramp (dir=1).
    // Bit 32 is dir, bits 31:0 are the level.
    function automatic logic [32:0] phase_init(input int i, input int ch_num,
                                               input int steps);
        int span;
        int p;
        span = 2 * (steps - 1);
        p    = (i * span) / ch_num;
        if (p <= steps - 1)
            return {1'b0, p};
        else
            return {1'b1, span - p};
    endfunction

    // A counter running 0..max_val needs $clog2(max_val+1) bits; a counter
    // that only ever holds 0 still gets one bit so the port is not empty.
    function automatic int cnt_width(input int max_val);
        if (max_val < 1)
            return 1;
        else
            return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/pwm_breath_ch.sv
// ---------------------------------------------------------------------------
// pwm_breath_ch
// One LED channel: breath level/direction, shadowed mode and registered
// LED output.
//   sys_clk, sys_rst : clock, asynchronous active-high reset
//   enable           : run/freeze; while low the output is held at 0
//   period_end       : strobe on the clock that ends a PWM period
//   cnt_pwm          : shared PWM position within the period
//   mode             : raw 2-bit mode strap for this channel
//   led              : registered LED drive, active-high
// ---------------------------------------------------------------------------
module pwm_breath_ch
    import pwm_breath_pkg::*;
#(
    parameter int               STEPS    = 1000,
    parameter int               PWM_W    = 10,
    parameter logic [PWM_W-1:0] INIT_LVL = '0,
    parameter logic             INIT_DIR = 1'b0
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             enable,
    input  logic             period_end,
    input  logic [PWM_W-1:0] cnt_pwm,
    input  logic [1:0]       mode,
    output logic             led
);

    localparam logic [PWM_W-1:0] LVL_TOP = PWM_W'(STEPS - 1);

    logic [PWM_W-1:0] lvl;
    logic             dir;
    logic [1:0]       mode_q;
    logic [PWM_W-1:0] lvl_next;
    logic             dir_next;
    logic             led_next;

    // Triangle walk: the extreme levels are visited once per turn, so the
    // step that reaches an end also reverses direction.
    always_comb begin
        lvl_next = lvl;
        dir_next = dir;
        if (!dir) begin
            if (lvl == LVL_TOP) begin
                lvl_next = LVL_TOP - 1'b1;
                dir_next = 1'b1;
            end else begin
                lvl_next = lvl + 1'b1;
            end
        end else begin
            if (lvl == '0) begin
                lvl_next = PWM_W'(1);
                dir_next = 1'b0;
            end else begin
                lvl_next = lvl - 1'b1;
            end
        end
    end

    always_comb begin
        led_next = 1'b0;
        case (mode_q)
            MODE_OFF:    led_next = 1'b0;
            MODE_ON:     led_next = 1'b1;
            MODE_BREATH: led_next = (cnt_pwm < lvl);
            MODE_BLINK:  led_next = dir;
            default:     led_next = 1'b0;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            lvl    <= INIT_LVL;
            dir    <= INIT_DIR;
            mode_q <= MODE_OFF;
            led    <= 1'b0;
        end else begin
            if (period_end) begin
                lvl <= lvl_next;
                dir <= dir_next;
            end
            // Mode is only taken at a period boundary so a running period is
            // never cut short; while frozen it tracks the strap freely.
            if (period_end || !enable)
                mode_q <= mode;
            led <= enable & led_next;
        end
    end

endmodule

// File: rtl/pwm_breath_multi.sv
// ---------------------------------------------------------------------------
// pwm_breath_multi
// Multi-channel breathing-LED PWM generator. Owns the tick prescaler, the
// shared PWM position counter and the period strobe; each channel's level,
// mode shadow and output live in pwm_breath_ch.
//   sys_clk, sys_rst : clock, asynchronous active-high reset
//   enable           : run (1) / freeze with outputs forced low (0)
//   mode             : bits [2i+1:2i] are channel i's mode
//                      (00 off, 01 on, 10 breath, 11 blink)
//   led_out          : registered LED drives, active-high
//   period_pulse     : one-cycle strobe following the last tick of a period
// ---------------------------------------------------------------------------
module pwm_breath_multi
    import pwm_breath_pkg::*;
#(
    parameter int CH_NUM       = 4,
    parameter int PRESC_MAX    = 50,
    parameter int STEPS        = 1000,
    parameter int PHASE_SPREAD = 1
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  enable,
    input  logic [2*CH_NUM-1:0]   mode,
    output logic [CH_NUM-1:0]     led_out,
    output logic                  period_pulse
);

    localparam int PRE_W = cnt_width(PRESC_MAX - 1);
    localparam int PWM_W = cnt_width(STEPS - 1);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESC_MAX - 1);
    localparam logic [PWM_W-1:0] PWM_LAST = PWM_W'(STEPS - 1);

    logic [PRE_W-1:0] cnt_pre;
    logic [PWM_W-1:0] cnt_pwm;
    logic             tick;
    logic             period_end;

    assign tick       = enable && (cnt_pre == PRE_LAST);
    assign period_end = tick && (cnt_pwm == PWM_LAST);

    // Prescaler: holds its value while frozen so the tick phase resumes
    // exactly where it stopped.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt_pre <= '0;
        end else if (enable) begin
            if (cnt_pre == PRE_LAST)
                cnt_pre <= '0;
            else
                cnt_pre <= cnt_pre + 1'b1;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt_pwm <= '0;
        end else if (tick) begin
            if (cnt_pwm == PWM_LAST)
                cnt_pwm <= '0;
            else
                cnt_pwm <= cnt_pwm + 1'b1;
        end
    end

    // period_end already carries enable, so the strobe is 0 while frozen.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst)
            period_pulse <= 1'b0;
        else
            period_pulse <= period_end;
    end

    for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
        // With spreading off every channel takes channel 0's phase (level 0,
        // rising).
        localparam logic [32:0] PH =
            phase_init((PHASE_SPREAD != 0) ? i : 0, CH_NUM, STEPS);

        pwm_breath_ch #(
            .STEPS    (STEPS),
            .PWM_W    (PWM_W),
            .INIT_LVL (PH[PWM_W-1:0]),
            .INIT_DIR (PH[32])
        ) u_ch (
            .sys_clk    (sys_clk),
            .sys_rst    (sys_rst),
            .enable     (enable),
            .period_end (period_end),
            .cnt_pwm    (cnt_pwm),
            .mode       (mode[2*i +: 2]),
            .led        (led_out[i])
        );
    end

endmodule

// File: tb/tb_pwm_breath_multi.sv
// ---------------------------------------------------------------------------
// tb_pwm_breath_multi
// Directed bench for pwm_breath_multi with PRESC_MAX=2, STEPS=4, CH_NUM=4,
// PHASE_SPREAD=1: a period is 8 clocks, a breath cycle 6 periods.
// Each queued entry holds the expected 8-sample waveform of every channel
// for one period, {ch3, ch2, ch1, ch0}, sample j in bit j.
// ---------------------------------------------------------------------------
module tb_pwm_breath_multi;

    localparam int CH  = 4;
    localparam int PRE = 2;
    localparam int ST  = 4;
    localparam int PER = PRE * ST;

    logic           clk = 1'b0;
    logic           rst;
    logic           enable;
    logic [2*CH-1:0] mode;
    logic [CH-1:0]  led_out;
    logic           period_pulse;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    pwm_breath_multi #(
        .CH_NUM       (CH),
        .PRESC_MAX    (PRE),
        .STEPS        (ST),
        .PHASE_SPREAD (1)
    ) dut (
        .sys_clk      (clk),
        .sys_rst      (rst),
        .enable       (enable),
        .mode         (mode),
        .led_out      (led_out),
        .period_pulse (period_pulse)
    );

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Breath waveform for level l: high for the first 2*l samples.
    function automatic logic [7:0] bw(input int l);
        logic [15:0] one;
        one = 16'd1;
        return 8'((one << (2 * l)) - 16'd1);
    endfunction

    // Constant waveform (on / blink).
    function automatic logic [7:0] kw(input logic b);
        return b ? 8'hFF : 8'h00;
    endfunction

    // ---------------- driver tasks ----------------
    // Wait for period_pulse, counting negedges; expect it on the exp_cnt-th.
    task automatic wait_pulse(input string tag, input int exp_cnt);
        int cnt;
        int k;
        cnt = 0;
        k   = 0;
        while (cnt == 0 && k < 64) begin
            @(negedge clk);
            k++;
            if (period_pulse)
                cnt = k;
        end
        check_eq(tag, cnt, exp_cnt);
    endtask

    // Called on the negedge where period_pulse is seen. Samples one period,
    // optionally freezing enable after sample frz_at for frz_len clocks and
    // changing mode after sample chg_at. Ends on the next pulse negedge.
    task automatic run_period(input string tag, input int frz_at,
                              input int frz_len, input int chg_at,
                              input logic [7:0] chg_mode);
        logic [7:0]  wave [CH];
        logic [CH-1:0] frz_or;
        logic [31:0] exp_w;
        int j;
        int early;
        j      = 0;
        early  = 0;
        frz_or = '0;
        for (int c = 0; c < CH; c++)
            wave[c] = 8'h00;
        for (int n = 1; n <= PER + frz_len; n++) begin
            @(negedge clk);
            if (frz_len > 0 && n > frz_at && n <= frz_at + frz_len) begin
                frz_or = frz_or | led_out;
            end else if (j < PER) begin
                for (int c = 0; c < CH; c++)
                    wave[c][j] = led_out[c];
                j++;
            end
            if (n < PER + frz_len && period_pulse)
                early++;
            if (n == chg_at)
                mode = chg_mode;
            if (frz_len > 0 && n == frz_at)
                enable = 1'b0;
            if (frz_len > 0 && n == frz_at + frz_len)
                enable = 1'b1;
        end
        check_eq({tag, "_pulse_end"}, period_pulse, 1);
        check_eq({tag, "_pulse_early"}, early, 0);
        if (frz_len > 0)
            check_eq({tag, "_frozen_led"}, frz_or, 0);
        if (exp_q.size() == 0) begin
            check_eq({tag, "_exp_q_empty"}, 1, 0);
        end else begin
            exp_w = exp_q.pop_front();
            for (int c = 0; c < CH; c++)
                check_eq($sformatf("%s_ch%0d", tag, c), wave[c], exp_w[8*c +: 8]);
        end
    endtask

    // ---------------- stimulus ----------------
    // Hand-derived breath levels for periods 1..8 after reset release
    // (reset levels 0,1,3,2 with dirs 0,0,0,1). ch1 switches to on in period 8.
    int lv0 [8] = '{1, 2, 3, 2, 1, 0, 1, 2};
    int lv1 [8] = '{2, 3, 2, 1, 0, 1, 2, 0};
    int lv2 [8] = '{2, 1, 0, 1, 2, 3, 2, 1};
    int lv3 [8] = '{1, 0, 1, 2, 3, 2, 1, 0};
    // Hand-derived blink outputs {ch3..ch0} for periods 1..9.
    logic [3:0] blk [9] = '{4'hC, 4'hC, 4'h6, 4'h3, 4'h3, 4'h9, 4'hC, 4'hC, 4'h6};

    initial begin
        logic [7:0] w1;
        rst    = 1'b1;
        enable = 1'b1;
        mode   = 8'h55;
        repeat (3) @(negedge clk);
        check_eq("rst_led", led_out, 0);
        check_eq("rst_pulse", period_pulse, 0);

        // Reset release: first strobe after 8 clocks, all-on period next.
        rst = 1'b0;
        wait_pulse("first_pulse", PER);
        exp_q.push_back(32'hFFFF_FFFF);
        run_period("on_p1", 0, 0, 0, mode);

        // Asynchronous reset while the strobe and LEDs are high.
        check_eq("pre_rst_led", led_out, 4'hF);
        #2 rst = 1'b1;
        #1;
        check_eq("async_rst_led", led_out, 0);
        check_eq("async_rst_pulse", period_pulse, 0);
        mode = 8'hAA;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        wait_pulse("rel_pulse", PER);

        // Breath with stagger, freeze in period 5, ch1 -> on during period 7.
        for (int k = 0; k < 8; k++) begin
            w1 = (k == 7) ? 8'hFF : bw(lv1[k]);
            exp_q.push_back({bw(lv3[k]), bw(lv2[k]), w1, bw(lv0[k])});
        end
        run_period("br_p1", 0, 0, 0, mode);
        run_period("br_p2", 0, 0, 0, mode);
        run_period("br_p3", 0, 0, 0, mode);
        run_period("br_p4", 0, 0, 0, mode);
        run_period("br_p5_frz", 3, 5, 0, mode);
        run_period("br_p6", 0, 0, 0, mode);
        run_period("br_p7_chg", 0, 0, 3, 8'hA6);
        run_period("br_p8", 0, 0, 0, mode);

        // Blink on all channels from a fresh reset.
        rst  = 1'b1;
        mode = 8'hFF;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        wait_pulse("blink_pulse", PER);
        for (int k = 0; k < 9; k++)
            exp_q.push_back({kw(blk[k][3]), kw(blk[k][2]), kw(blk[k][1]), kw(blk[k][0])});
        for (int k = 0; k < 9; k++)
            run_period($sformatf("bl_p%0d", k + 1), 0, 0, 0, mode);

        check_eq("exp_q_drained", exp_q.size(), 0);

        // ---------------- report ----------------
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
